gpr_wb_pipe: RTL and testbench

GPR_WB_PIPE -- requirements
Module: gpr_wb_pipe

---
 rtl/gpr_pkg.sv | 34 +++
 rtl/gpr_regfile.sv | 54 +++++
 rtl/gpr_wb_pipe.sv | 100 ++++++++++
 tb/tb_gpr_wb_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR writeback pipeline: register file geometry,
// load-type codes and the load data extraction helper.
package gpr_pkg;

  localparam int unsigned NumGpr = 32;
  localparam int unsigned AddrW  = 5;
  localparam int unsigned DataW  = 32;

  typedef enum logic [2:0] {
    LdLw  = 3'd0,
    LdLb  = 3'd1,
    LdLbu = 3'd2,
    LdLh  = 3'd3,
    LdLhu = 3'd4
  } load_type_e;

  // Unknown codes fall through to a full-word load.
  function automatic logic [DataW-1:0] load_extract(input logic [2:0]       load_type,
                                                    input logic [1:0]       addr,
                                                    input logic [DataW-1:0] rdata);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    w_byte = 8'(rdata >> {addr, 3'b000});
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LdLb:    load_extract = {{24{w_byte[7]}}, w_byte};
      LdLbu:   load_extract = {24'h0, w_byte};
      LdLh:    load_extract = {{16{w_half[15]}}, w_half};
      LdLhu:   load_extract = {16'h0, w_half};
      default: load_extract = rdata;
    endcase
  endfunction

endpackage

// File: rtl/gpr_regfile.sv
// 32x32 general purpose register file, two combinational read ports, one write port.
// GPR_WB_WRITE_THROUGH_EN forwards the pending write to matching reads.
module gpr_regfile
  import gpr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [DataW-1:0] i_wdata,
  input  logic [AddrW-1:0] i_raddr1,
  input  logic [AddrW-1:0] i_raddr2,
  output logic [DataW-1:0] o_rdata1,
  output logic [DataW-1:0] o_rdata2
);

  logic [DataW-1:0] r_gpr [NumGpr];
  logic             w_wr;

  assign w_wr = i_we && (i_waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumGpr; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_wr) begin
      r_gpr[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = '0;
    if (i_raddr1 != '0) begin
`ifdef GPR_WB_WRITE_THROUGH_EN
      o_rdata1 = (w_wr && (i_waddr == i_raddr1)) ? i_wdata : r_gpr[i_raddr1];
`else
      o_rdata1 = r_gpr[i_raddr1];
`endif
    end
  end

  always_comb begin
    o_rdata2 = '0;
    if (i_raddr2 != '0) begin
`ifdef GPR_WB_WRITE_THROUGH_EN
      o_rdata2 = (w_wr && (i_waddr == i_raddr2)) ? i_wdata : r_gpr[i_raddr2];
`else
      o_rdata2 = r_gpr[i_raddr2];
`endif
    end
  end

endmodule

// File: rtl/gpr_wb_pipe.sv
// EXE -> MEM -> WB tail of the pipeline with load data alignment and GPR writeback.
// Optional GPR_WB_WRITE_THROUGH_EN makes WB data visible to ID reads in the same cycle.
module gpr_wb_pipe
  import gpr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_EXE_valid,
  input  logic [AddrW-1:0] i_EXE_waddr,
  input  logic [DataW-1:0] i_EXE_result,
  input  logic             i_EXE_is_load,
  input  logic [2:0]       i_EXE_load_type,
  input  logic [DataW-1:0] i_MEM_rdata,
  output logic             o_EXE_get_result_in_EXE,
  output logic             o_EXE_get_result_in_MEM,
  output logic             o_MEM_get_result_in_MEM,
  output logic [AddrW-1:0] o_MEM_waddr,
  output logic [DataW-1:0] o_MEM_wdata,
  input  logic [AddrW-1:0] i_ID_raddr1,
  input  logic [AddrW-1:0] i_ID_raddr2,
  output logic [DataW-1:0] o_ID_rdata1,
  output logic [DataW-1:0] o_ID_rdata2
);

  logic             r_mem_valid;
  logic [AddrW-1:0] r_mem_waddr;
  logic [DataW-1:0] r_mem_result;
  logic             r_mem_is_load;
  logic [2:0]       r_mem_load_type;

  logic             r_wb_valid;
  logic [AddrW-1:0] r_wb_waddr;
  logic [DataW-1:0] r_wb_data;

  logic [DataW-1:0] w_mem_wdata;

  assign o_EXE_get_result_in_EXE = i_EXE_valid & ~i_EXE_is_load;
  assign o_EXE_get_result_in_MEM = i_EXE_valid & i_EXE_is_load;

  // Flush wins over stall so a squashed instruction never lingers in MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid     <= 1'b0;
      r_mem_waddr     <= '0;
      r_mem_result    <= '0;
      r_mem_is_load   <= 1'b0;
      r_mem_load_type <= '0;
    end else if (i_flush) begin
      r_mem_valid     <= 1'b0;
      r_mem_waddr     <= '0;
      r_mem_result    <= '0;
      r_mem_is_load   <= 1'b0;
      r_mem_load_type <= '0;
    end else if (!i_stall) begin
      r_mem_valid     <= i_EXE_valid;
      r_mem_waddr     <= i_EXE_waddr;
      r_mem_result    <= i_EXE_result;
      r_mem_is_load   <= i_EXE_is_load;
      r_mem_load_type <= i_EXE_load_type;
    end
  end

  always_comb begin
    w_mem_wdata = r_mem_result;
    if (r_mem_is_load) begin
      w_mem_wdata = load_extract(r_mem_load_type, r_mem_result[1:0], i_MEM_rdata);
    end
  end

  assign o_MEM_get_result_in_MEM = r_mem_valid;
  assign o_MEM_waddr             = r_mem_waddr;
  assign o_MEM_wdata             = w_mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_waddr <= '0;
      r_wb_data  <= '0;
    end else if (!i_stall) begin
      r_wb_valid <= r_mem_valid;
      r_wb_waddr <= r_mem_waddr;
      r_wb_data  <= w_mem_wdata;
    end
  end

  gpr_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (r_wb_valid),
    .i_waddr  (r_wb_waddr),
    .i_wdata  (r_wb_data),
    .i_raddr1 (i_ID_raddr1),
    .i_raddr2 (i_ID_raddr2),
    .o_rdata1 (o_ID_rdata1),
    .o_rdata2 (o_ID_rdata2)
  );

endmodule

// File: tb/tb_gpr_wb_pipe.sv
// Self-checking bench for gpr_wb_pipe: directed scenarios plus randomized traffic
// compared against a stage-level reference model.
module tb_gpr_wb_pipe;

`ifdef GPR_WB_WRITE_THROUGH_EN
  localparam bit WriteThrough = 1'b1;
`else
  localparam bit WriteThrough = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_stall, i_flush;
  logic        i_EXE_valid, i_EXE_is_load;
  logic [4:0]  i_EXE_waddr;
  logic [31:0] i_EXE_result, i_MEM_rdata;
  logic [2:0]  i_EXE_load_type;
  logic        o_EXE_get_result_in_EXE, o_EXE_get_result_in_MEM, o_MEM_get_result_in_MEM;
  logic [4:0]  o_MEM_waddr, i_ID_raddr1, i_ID_raddr2;
  logic [31:0] o_MEM_wdata, o_ID_rdata1, o_ID_rdata2;

  int checks = 0;
  int errors = 0;

  // Reference model state: one record per stage plus the architectural registers.
  logic        m_v;
  logic [4:0]  m_a;
  logic [31:0] m_res;
  logic        m_ld;
  logic [2:0]  m_lt;
  logic        w_v;
  logic [4:0]  w_a;
  logic [31:0] w_d;
  logic [31:0] gpr [32];

  always #5 clk = ~clk;

  gpr_wb_pipe dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_stall                 (i_stall),
    .i_flush                 (i_flush),
    .i_EXE_valid             (i_EXE_valid),
    .i_EXE_waddr             (i_EXE_waddr),
    .i_EXE_result            (i_EXE_result),
    .i_EXE_is_load           (i_EXE_is_load),
    .i_EXE_load_type         (i_EXE_load_type),
    .i_MEM_rdata             (i_MEM_rdata),
    .o_EXE_get_result_in_EXE (o_EXE_get_result_in_EXE),
    .o_EXE_get_result_in_MEM (o_EXE_get_result_in_MEM),
    .o_MEM_get_result_in_MEM (o_MEM_get_result_in_MEM),
    .o_MEM_waddr             (o_MEM_waddr),
    .o_MEM_wdata             (o_MEM_wdata),
    .i_ID_raddr1             (i_ID_raddr1),
    .i_ID_raddr2             (i_ID_raddr2),
    .o_ID_rdata1             (o_ID_rdata1),
    .o_ID_rdata2             (o_ID_rdata2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_wdata(input logic ld, input logic [2:0] lt,
                                            input logic [31:0] res, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * res[1:0])) % 256;
    h = (rd >> (16 * res[1])) % 65536;
    if (!ld) return res;
    case (lt)
      3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (WriteThrough && w_v && w_a == a) return w_d;
    return gpr[a];
  endfunction

  task automatic model_reset();
    m_v = 0; m_a = 0; m_res = 0; m_ld = 0; m_lt = 0;
    w_v = 0; w_a = 0; w_d = 0;
    for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
  endtask

  task automatic model_edge();
    logic [31:0] mem_data;
    mem_data = ref_wdata(m_ld, m_lt, m_res, i_MEM_rdata);
    if (w_v && w_a != 0) gpr[w_a] = w_d;
    if (!i_stall) begin
      w_v = m_v; w_a = m_a; w_d = mem_data;
    end
    if (i_flush) begin
      m_v = 0; m_a = 0; m_res = 0; m_ld = 0; m_lt = 0;
    end else if (!i_stall) begin
      m_v = i_EXE_valid; m_a = i_EXE_waddr; m_res = i_EXE_result;
      m_ld = i_EXE_is_load; m_lt = i_EXE_load_type;
    end
  endtask

  task automatic check_all();
    chk("exe_in_exe", {31'b0, o_EXE_get_result_in_EXE}, {31'b0, i_EXE_valid & ~i_EXE_is_load});
    chk("exe_in_mem", {31'b0, o_EXE_get_result_in_MEM}, {31'b0, i_EXE_valid & i_EXE_is_load});
    chk("mem_valid", {31'b0, o_MEM_get_result_in_MEM}, {31'b0, m_v});
    chk("mem_waddr", {27'b0, o_MEM_waddr}, {27'b0, m_a});
    chk("mem_wdata", o_MEM_wdata, ref_wdata(m_ld, m_lt, m_res, i_MEM_rdata));
    chk("id_rdata1", o_ID_rdata1, ref_read(i_ID_raddr1));
    chk("id_rdata2", o_ID_rdata2, ref_read(i_ID_raddr2));
  endtask

  task automatic set_in(input logic v, input logic [4:0] a, input logic [31:0] res,
                        input logic ld, input logic [2:0] lt, input logic st, input logic fl,
                        input logic [31:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    i_EXE_valid = v; i_EXE_waddr = a; i_EXE_result = res; i_EXE_is_load = ld;
    i_EXE_load_type = lt; i_stall = st; i_flush = fl; i_MEM_rdata = rd;
    i_ID_raddr1 = r1; i_ID_raddr2 = r2;
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    set_in(1, 5'd4, 32'h1111, 0, 0, 0, 0, 32'hA5A5_A5A5, 5'd4, 5'd0);
    #12;
    chk("reset_mem_valid", {31'b0, o_MEM_get_result_in_MEM}, 32'h0);
    chk("reset_wdata", o_MEM_wdata, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // ALU result to r5
    set_in(1, 5'd5, 32'h1234, 0, 0, 0, 0, 32'h0, 5'd5, 5'd0);
    tick();
    set_in(0, 5'd0, 32'h0, 0, 0, 0, 0, 32'h0, 5'd5, 5'd0);
    #1;
    chk("alu_e1_valid", {31'b0, o_MEM_get_result_in_MEM}, 32'h1);
    chk("alu_e1_waddr", {27'b0, o_MEM_waddr}, 32'd5);
    chk("alu_e1_wdata", o_MEM_wdata, 32'h1234);
    chk("alu_e1_r5", o_ID_rdata1, 32'h0);
    tick();
    #1;
    chk("alu_e2_r5", o_ID_rdata1, WriteThrough ? 32'h1234 : 32'h0);
    tick();
    #1;
    chk("alu_e3_r5", o_ID_rdata1, 32'h1234);

    // LB then LHU from the same unaligned address
    set_in(1, 5'd7, 32'h0000_1003, 1, 3'd1, 0, 0, 32'h0, 5'd7, 5'd8);
    tick();
    set_in(1, 5'd8, 32'h0000_1003, 1, 3'd4, 0, 0, 32'h80FF_0000, 5'd7, 5'd8);
    #1;
    chk("lb_wdata", o_MEM_wdata, 32'hFFFF_FF80);
    tick();
    set_in(1, 5'd7, 32'h0000_2003, 1, 3'd1, 0, 0, 32'h80FF_0000, 5'd7, 5'd8);
    #1;
    chk("lhu_wdata", o_MEM_wdata, 32'h0000_80FF);
    tick();

    // Stall three edges with a load in MEM, then release once
    set_in(1, 5'd9, 32'h0000_0042, 0, 0, 1, 0, 32'h80FF_0000, 5'd7, 5'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("stall_wdata", o_MEM_wdata, 32'hFFFF_FF80);
      chk("stall_waddr", {27'b0, o_MEM_waddr}, 32'd7);
    end
    i_stall = 1'b0;
    tick();
    #1;
    chk("release_waddr", {27'b0, o_MEM_waddr}, 32'd9);
    chk("release_wdata", o_MEM_wdata, 32'h42);

    // Simultaneous stall and flush
    set_in(1, 5'd10, 32'h0BAD, 0, 0, 1, 1, 32'h0, 5'd9, 5'd7);
    tick();
    #1;
    chk("flush_mem_valid", {31'b0, o_MEM_get_result_in_MEM}, 32'h0);
    set_in(0, 5'd0, 32'h0, 0, 0, 0, 0, 32'h0, 5'd9, 5'd7);
    tick();
    tick();

    // Writes to r0 are discarded
    set_in(1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 32'h0, 5'd0, 5'd0);
    tick();
    set_in(0, 5'd0, 32'h0, 0, 0, 0, 0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("r0_zero", o_ID_rdata1, 32'h0);
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 9) < 8, 5'($urandom), $urandom, $urandom_range(0, 9) < 4,
             3'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
             5'($urandom), 5'($urandom));
      tick();
    end

    // Reset asserted while stalled with a load in flight
    set_in(1, 5'd12, 32'h0000_0001, 1, 3'd3, 0, 0, 32'h1234_5678, 5'd0, 5'd0);
    tick();
    i_stall = 1'b1;
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mem_valid", {31'b0, o_MEM_get_result_in_MEM}, 32'h0);
    chk("rst_mem_waddr", {27'b0, o_MEM_waddr}, 32'h0);
    chk("rst_mem_wdata", o_MEM_wdata, 32'h0);
    for (int i = 0; i < 32; i++) begin
      i_ID_raddr1 = 5'(i);
      i_ID_raddr2 = 5'(31 - i);
      #0.1;
      chk("rst_gpr1", o_ID_rdata1, 32'h0);
      chk("rst_gpr2", o_ID_rdata2, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 5'd3, 32'h55, 0, 0, 0, 0, 32'h0, 5'd3, 5'd12);
    tick();
    #1;
    chk("post_rst_valid", {31'b0, o_MEM_get_result_in_MEM}, 32'h1);
    chk("post_rst_waddr", {27'b0, o_MEM_waddr}, 32'd3);
    chk("post_rst_wdata", o_MEM_wdata, 32'h55);
    set_in(0, 5'd0, 32'h0, 0, 0, 0, 0, 32'h0, 5'd3, 5'd12);
    tick();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
